// File: rtl/rr_log_packer_pkg.sv
// Shared types and elaboration-time helpers for the record/replay log packer.
package rr_log_packer_pkg;

    // Width of one entry in a channel-width table.
    localparam int RR_CHANNEL_WIDTH_BITS = 32;
    // Upper bound on begin channels a width table can describe.
    localparam int RR_MAX_CHANNELS = 16;

    // Fixed-size width table. Callers zero-extend their own tables into this
    // type so that the helpers below can take a single argument type.
    typedef logic [RR_MAX_CHANNELS-1:0][RR_CHANNEL_WIDTH_BITS-1:0] rr_widths_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } rr_packer_state_t;

    // Bit offset of channel idx inside the flattened logb_data bus.
    function automatic int rr_get_offset(input rr_widths_t widths, input int idx);
        int acc;
        acc = 0;
        for (int j = 0; j < RR_MAX_CHANNELS; j++) begin
            if (j < idx) begin
                acc = acc + int'(widths[j]);
            end
        end
        return acc;
    endfunction

    // Header is one valid bit per begin channel plus one per end channel.
    function automatic int rr_hdr_w(input int logb_cnt, input int loge_cnt);
        return logb_cnt + loge_cnt;
    endfunction

    // Largest packet: header plus every begin channel present.
    function automatic int rr_max_pkt_w(input rr_widths_t widths, input int logb_cnt,
                                        input int loge_cnt);
        return rr_hdr_w(logb_cnt, loge_cnt) + rr_get_offset(widths, logb_cnt);
    endfunction

endpackage

// File: rtl/rr_packet_compactor.sv
// Combinational packet builder: header followed by the valid begin channels
// packed back to back in ascending index, plus the resulting packet length.
module rr_packet_compactor
    import rr_log_packer_pkg::*;
#(
    parameter int LOGB_CHANNEL_CNT = 3,
    parameter int LOGE_CHANNEL_CNT = 5,
    parameter logic [LOGB_CHANNEL_CNT-1:0][RR_CHANNEL_WIDTH_BITS-1:0] CHANNEL_WIDTHS =
        {32'd96, 32'd577, 32'd96},
    parameter int MAX_PKT_W = rr_max_pkt_w(rr_widths_t'(CHANNEL_WIDTHS),
                                           LOGB_CHANNEL_CNT, LOGE_CHANNEL_CNT),
    parameter int LEN_W = $clog2(MAX_PKT_W + 1)
) (
    input  logic [LOGB_CHANNEL_CNT-1:0] logb_valid,
    input  logic [rr_get_offset(rr_widths_t'(CHANNEL_WIDTHS), LOGB_CHANNEL_CNT)-1:0] logb_data,
    input  logic [LOGE_CHANNEL_CNT-1:0] loge_valid,
    output logic [MAX_PKT_W-1:0]        packet,
    output logic [LEN_W-1:0]            len
);

    localparam rr_widths_t WIDTHS_EXT = rr_widths_t'(CHANNEL_WIDTHS);
    localparam int HDR_W = rr_hdr_w(LOGB_CHANNEL_CNT, LOGE_CHANNEL_CNT);

    // offs_s[i] is the packet bit where channel i lands if it is valid; the
    // chain starts at HDR_W so the final entry is the packet length itself.
    logic [LEN_W-1:0]     offs_s   [LOGB_CHANNEL_CNT+1];
    logic [MAX_PKT_W-1:0] placed_s [LOGB_CHANNEL_CNT];

    assign offs_s[0] = LEN_W'(HDR_W);

    for (genvar i = 0; i < LOGB_CHANNEL_CNT; i++) begin : g_chan
        localparam int CH_W   = int'(WIDTHS_EXT[i]);
        localparam int CH_OFF = rr_get_offset(WIDTHS_EXT, i);

        logic [CH_W-1:0] chan_s;

        assign chan_s        = logb_data[CH_OFF +: CH_W];
        assign offs_s[i+1]   = offs_s[i] + (logb_valid[i] ? LEN_W'(CH_W) : LEN_W'(0));
        assign placed_s[i]   = logb_valid[i] ? (MAX_PKT_W'(chan_s) << offs_s[i])
                                             : {MAX_PKT_W{1'b0}};
    end

    // Merge header and the non-overlapping placed channel slices.
    always_comb begin
        packet = MAX_PKT_W'({loge_valid, logb_valid});
        for (int i = 0; i < LOGB_CHANNEL_CNT; i++) begin
            packet = packet | placed_s[i];
        end
    end

    assign len = offs_s[LOGB_CHANNEL_CNT];

endmodule

// File: rtl/rr_log_packer.sv
// Log packer top: captures one logging cycle into a packet register and
// serializes it as OUT_WIDTH-bit beats with a last flag.
module rr_log_packer
    import rr_log_packer_pkg::*;
#(
    parameter int LOGB_CHANNEL_CNT = 3,
    parameter int LOGE_CHANNEL_CNT = 5,
    parameter logic [LOGB_CHANNEL_CNT-1:0][RR_CHANNEL_WIDTH_BITS-1:0] CHANNEL_WIDTHS =
        {32'd96, 32'd577, 32'd96},
    parameter int OUT_WIDTH = 512
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [LOGB_CHANNEL_CNT-1:0] logb_valid,
    input  logic [rr_get_offset(rr_widths_t'(CHANNEL_WIDTHS), LOGB_CHANNEL_CNT)-1:0] logb_data,
    input  logic [LOGE_CHANNEL_CNT-1:0] loge_valid,
    output logic                        ready,
    output logic                        out_valid,
    output logic [OUT_WIDTH-1:0]        out_data,
    output logic                        out_last,
    input  logic                        out_ready,
    output logic [31:0]                 pkt_cnt
);

    localparam rr_widths_t WIDTHS_EXT = rr_widths_t'(CHANNEL_WIDTHS);
    localparam int MAX_PKT_W  = rr_max_pkt_w(WIDTHS_EXT, LOGB_CHANNEL_CNT, LOGE_CHANNEL_CNT);
    localparam int LEN_W      = $clog2(MAX_PKT_W + 1);
    localparam int OUT_W_DIV  = (OUT_WIDTH > 0) ? OUT_WIDTH : 1;
    localparam int NBEATS_MAX = (MAX_PKT_W + OUT_W_DIV - 1) / OUT_W_DIV;
    localparam int BEAT_IDX_W = $clog2(NBEATS_MAX + 1);
    localparam int PAD_W      = NBEATS_MAX * OUT_W_DIV;

    if (OUT_WIDTH == 0) begin : g_chk_out_width
        $error("rr_log_packer: OUT_WIDTH must be non-zero");
    end

    for (genvar i = 0; i < LOGB_CHANNEL_CNT; i++) begin : g_chk_width
        if (CHANNEL_WIDTHS[i] == {RR_CHANNEL_WIDTH_BITS{1'b0}}) begin : g_zero
            $error("rr_log_packer: CHANNEL_WIDTHS[%0d] is zero", i);
        end
    end

    rr_packer_state_t      state_r;
    rr_packer_state_t      state_next_s;
    logic [MAX_PKT_W-1:0]  packet_s;
    logic [LEN_W-1:0]      len_s;
    logic [PAD_W-1:0]      padded_s;
    logic [PAD_W-1:0]      rest_r;
    logic [BEAT_IDX_W-1:0] nbeats_s;
    logic [BEAT_IDX_W-1:0] nbeats_r;
    logic [BEAT_IDX_W-1:0] beat_idx_r;
    logic                  hs_s;
    logic                  capture_s;
    logic                  load_s;
    logic                  adv_s;
    logic                  done_s;

    rr_packet_compactor #(
        .LOGB_CHANNEL_CNT (LOGB_CHANNEL_CNT),
        .LOGE_CHANNEL_CNT (LOGE_CHANNEL_CNT),
        .CHANNEL_WIDTHS   (CHANNEL_WIDTHS),
        .MAX_PKT_W        (MAX_PKT_W),
        .LEN_W            (LEN_W)
    ) u_compactor (
        .logb_valid (logb_valid),
        .logb_data  (logb_data),
        .loge_valid (loge_valid),
        .packet     (packet_s),
        .len        (len_s)
    );

    assign padded_s = PAD_W'(packet_s);

    // Beat count: one beat always, plus one for each further OUT_WIDTH boundary len crosses.
    always_comb begin
        nbeats_s = BEAT_IDX_W'(1);
        for (int k = 1; k < NBEATS_MAX; k++) begin
            if (len_s > LEN_W'(k * OUT_WIDTH)) begin
                nbeats_s = nbeats_s + BEAT_IDX_W'(1);
            end else begin
                nbeats_s = nbeats_s;
            end
        end
    end

    // Accept is combinational from out_ready so a new packet can load on the final handshake.
    assign hs_s      = out_valid & out_ready;
    assign ready     = rstn & ((state_r == IDLE) | (hs_s & out_last));
    assign capture_s = ready & ((|logb_valid) | (|loge_valid));

    // Next-state and datapath strobes.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        adv_s        = 1'b0;
        done_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (capture_s) begin
                    load_s       = 1'b1;
                    state_next_s = SEND;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SEND: begin
                if (hs_s) begin
                    if (out_last) begin
                        done_s = 1'b1;
                        if (capture_s) begin
                            load_s       = 1'b1;
                            state_next_s = SEND;
                        end else begin
                            state_next_s = IDLE;
                        end
                    end else begin
                        adv_s        = 1'b1;
                        state_next_s = SEND;
                    end
                end else begin
                    state_next_s = SEND;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Packet shift register, registered beat outputs and completed-packet counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid  <= 1'b0;
            out_data   <= {OUT_WIDTH{1'b0}};
            out_last   <= 1'b0;
            rest_r     <= {PAD_W{1'b0}};
            nbeats_r   <= {BEAT_IDX_W{1'b0}};
            beat_idx_r <= {BEAT_IDX_W{1'b0}};
            pkt_cnt    <= 32'd0;
        end else begin
            out_valid <= (state_next_s == SEND);
            if (done_s) begin
                pkt_cnt <= pkt_cnt + 32'd1;
            end
            if (load_s) begin
                out_data   <= padded_s[OUT_WIDTH-1:0];
                rest_r     <= padded_s >> OUT_WIDTH;
                nbeats_r   <= nbeats_s;
                beat_idx_r <= {BEAT_IDX_W{1'b0}};
                out_last   <= (nbeats_s == BEAT_IDX_W'(1));
            end else if (adv_s) begin
                out_data   <= rest_r[OUT_WIDTH-1:0];
                rest_r     <= rest_r >> OUT_WIDTH;
                beat_idx_r <= beat_idx_r + BEAT_IDX_W'(1);
                out_last   <= ((beat_idx_r + BEAT_IDX_W'(2)) == nbeats_r);
            end else if (done_s) begin
                out_data <= {OUT_WIDTH{1'b0}};
                out_last <= 1'b0;
            end
        end
    end

endmodule

// File: doc/rr_log_packer.md
Name: rr_log_packer

Overview:
- Consumer end of the record/replay logging bus driven by the AXI master/slave recorders.
- Each accepted logging cycle is turned into one variable-length packet: a valid-mask header followed by the compacted payload of the valid begin-channels.
- The packet is serialized into OUT_WIDTH-bit beats with a last flag, for the downstream log FIFO/DMA writer.
- It supplies the broadcast `ready` that all channel loggers share.

Parameters:
- LOGB_CHANNEL_CNT, 3: number of begin channels that carry data.
- LOGE_CHANNEL_CNT, 5: number of end channels (valid only, no data).
- CHANNEL_WIDTHS, packed [LOGB_CHANNEL_CNT-1:0][RR_CHANNEL_WIDTH_BITS-1:0], AW/W/AR widths: data width of each begin channel.
- OUT_WIDTH, 512: output beat width in bits.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- logb_valid  in  LOGB_CHANNEL_CNT  per-channel begin valid
- logb_data  in  sum(CHANNEL_WIDTHS)  channel i occupies [GET_OFFSET(i) +: CHANNEL_WIDTHS[i]]
- loge_valid  in  LOGE_CHANNEL_CNT  per-channel end valid
- ready  out  1  broadcast accept to all loggers
- out_valid  out  1  beat valid
- out_data  out  OUT_WIDTH  beat data
- out_last  out  1  final beat of the packet
- out_ready  in  1  downstream accept
- pkt_cnt  out  32  packets fully emitted; wraps

Behaviour:
- Capture condition: `ready && (|logb_valid || |loge_valid)` at a rising clk. When all valids are 0, nothing is captured, even if `ready` is high.
- Packet layout, bit 0 = LSB:
  - HDR_W = LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT.
  - Header = {loge_valid, logb_valid}.
  - Payload starts at bit HDR_W: valid begin channels in ascending index, packed with no gaps. Invalid channels take no space.
  - Unused bits up to MAX_PKT_W = HDR_W + sum(CHANNEL_WIDTHS) are 0.
- Length arithmetic:
  - len = HDR_W + sum of CHANNEL_WIDTHS[i] over valid i; computed at capture.
  - nbeats = ceil(len / OUT_WIDTH), always ≥ 1.
  - Beat k = packet[k*OUT_WIDTH +: OUT_WIDTH], zero-extended past MAX_PKT_W.
- State machine:
  - IDLE: `ready` = 1. On capture, register the packet and nbeats, set beat index to 0, go to SEND.
  - SEND: `out_valid` = 1. On `out_valid && out_ready`, advance the beat index.
  - On the handshake of the last beat (index == nbeats-1, `out_last` = 1): increment pkt_cnt; go to IDLE, unless a new capture occurs in the same cycle, in which case stay in SEND with the new packet.
- Ready rule: `ready = (state == IDLE) || (out_valid && out_ready && out_last)`. This is a combinational path from out_ready, so back-to-back packets need no bubble.
- Latency: a capture at edge T gives `out_valid` = 1 after T, i.e. beat 0 is visible in the cycle after capture.
- Out-stage rules:
  - out_data, out_last and the beat index hold steady while `out_valid && !out_ready`.
  - out_valid never drops without a handshake.
- Input stability: loggers hold their valid/data while `ready` = 0; the packer relies on this and does no input buffering.
- Reset (asynchronous, rstn = 0):
  - state = IDLE; out_valid = 0; out_last = 0; out_data = 0; pkt_cnt = 0; `ready` = 0 while in reset.
  - Reset in mid-packet discards the remaining beats; no partial last beat is emitted after reset release.
- Wrap-around: pkt_cnt wraps 0xFFFF_FFFF → 0.
- Elaboration checks (`$error`):
  - any CHANNEL_WIDTHS[i] == 0;
  - OUT_WIDTH == 0;
  - the beat-index counter width is derived as $clog2(ceil(MAX_PKT_W/OUT_WIDTH)+1).

Decomposition:
- Shared package (cl_fpgarr_types/defs):
  - RR_CHANNEL_WIDTH_BITS and the GET_OFFSET macro (reused).
  - New rr_packer_state_t enum {IDLE, SEND}.
  - New HDR_W / MAX_PKT_W helper function computed from CHANNEL_WIDTHS.
- One sub-module, rr_packet_compactor: purely combinational. It takes the valid mask and data, and produces the compacted packet and len via prefix-sum offsets in a generate loop.
- The top handles the FSM, the packet register and the serializer.

Test Plan (parameters: LOGB=2, LOGE=3, CHANNEL_WIDTHS[0]=8, [1]=12, OUT_WIDTH=16):
- End-only packet: logb_valid=00, loge_valid=100 → one beat 0x0010 with out_last=1; pkt_cnt=1.
- One begin channel: logb_valid=10, loge_valid=010, ch1=0xABC → beats 0x578A, then 0x0001 with last; ready=0 during beat 0.
- Both begin channels: logb_valid=11, loge_valid=011, ch0=0x5A, ch1=0x123 → beats 0x6B4F, then 0x0024 with last.
- Backpressure: out_ready=0 for 5 cycles in mid-packet → out_data and out_last stable, ready=0. Then back-to-back: the next capture happens in the same cycle as the last-beat handshake, with no idle cycle.
- All valids 0 with ready=1 → no capture, out_valid stays 0, pkt_cnt unchanged.
- rstn asserted during beat 0 of a 2-beat packet → out_valid=0 immediately. After release, ready=1 and no stray beat appears; pkt_cnt=0.
